// File: rtl/thor_pkg.sv
// Shared pipeline definitions used by IF_STAGE, ins_queue and ID_STAGE.
// PCs are carried at the widest supported width; each stage keeps only its low XLEN bits.
package thor_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          PC_MAX_W  = 64;

    typedef struct packed {
        logic [31:0]         insA;
        logic [31:0]         insB;
        logic                validB;
        logic [PC_MAX_W-1:0] pc;
    } ins_bundle_t;

endpackage

// File: rtl/ins_queue_if.sv
// Fetch/decode side signals of the instruction queue, plus pointer debug taps.
// Handshake: a bundle moves in on a clock edge where push=1 and queueFull=0, and out on an
// edge where pop=1 and queueEmpty=0; flush=1 cancels both for that edge and empties the queue.
interface ins_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic            flush;
    logic            push;
    logic [31:0]     insAIn;
    logic [31:0]     insBIn;
    logic            validBIn;
    logic [XLEN-1:0] pcIn;
    logic            queueFull;
    logic            queueEmpty;
    logic            pop;
    logic [31:0]     insA;
    logic [31:0]     insB;
    logic            validB;
    logic [XLEN-1:0] pcOut;
    logic [CW-1:0]   count;
    logic [PW-1:0]   dbgRdPtr;
    logic [PW-1:0]   dbgWrPtr;

    modport master (
        output flush, push, insAIn, insBIn, validBIn, pcIn, pop,
        input  queueFull, queueEmpty, insA, insB, validB, pcOut, count, dbgRdPtr, dbgWrPtr
    );

    modport slave (
        input  flush, push, insAIn, insBIn, validBIn, pcIn, pop,
        output queueFull, queueEmpty, insA, insB, validB, pcOut, count, dbgRdPtr, dbgWrPtr
    );

endinterface

// File: rtl/ins_queue.sv
// Circular bundle FIFO between fetch and decode; head is visible combinationally,
// flags decode from a separate occupancy counter.
module ins_queue
    import thor_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      resetn,
    ins_queue_if.slave q
);

    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          pushAcc;
    logic          popAcc;
    ins_bundle_t   mem [DEPTH];
    ins_bundle_t   head;
    logic          unused_pc_hi;

    assign q.queueEmpty = (count == '0);
    assign q.queueFull  = (count == FULL_CNT);
    assign q.count      = count;
    assign q.dbgRdPtr   = rdPtr;
    assign q.dbgWrPtr   = wrPtr;

    assign pushAcc = q.push && !q.queueFull  && !q.flush;
    assign popAcc  = q.pop  && !q.queueEmpty && !q.flush;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (q.flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pushAcc) wrPtr <= wrPtr + PW'(1);
            if (popAcc)  rdPtr <= rdPtr + PW'(1);
            case ({pushAcc, popAcc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads an entry until count says it was written.
    always_ff @(posedge clock) begin
        if (pushAcc) begin
            mem[wrPtr] <= '{insA:   q.insAIn,
                            insB:   q.insBIn,
                            validB: q.validBIn,
                            pc:     PC_MAX_W'(q.pcIn)};
        end
    end

    assign head         = mem[rdPtr];
    assign unused_pc_hi = ^head.pc;

    always_comb begin
        q.insA   = NOP_INSTR;
        q.insB   = NOP_INSTR;
        q.validB = 1'b0;
        q.pcOut  = '0;
        if (!q.queueEmpty) begin
            q.insA   = head.insA;
            q.insB   = head.insB;
            q.validB = head.validB;
            q.pcOut  = head.pc[XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_ins_queue.sv
// Directed bench for ins_queue (XLEN=32, DEPTH=4) with a PC scoreboard for ordering.
module tb_ins_queue;
    import thor_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clock;
    logic resetn;

    ins_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) qif ();

    ins_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .q      (qif.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] exp_q[$];
    int              m_count = 0;

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard update for one edge, from the bench's own occupancy model
    task automatic model_edge(input logic f, input logic pu, input logic po, input logic [XLEN-1:0] pc);
        bit pa, pp;
        if (f) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            pa = pu && (m_count < DEPTH);
            pp = po && (m_count > 0);
            if (pp) void'(exp_q.pop_front());
            if (pa) exp_q.push_back(pc);
            m_count = m_count + int'(pa) - int'(pp);
        end
    endtask

    task automatic idle_inputs();
        qif.flush    = 1'b0;
        qif.push     = 1'b0;
        qif.pop      = 1'b0;
        qif.insAIn   = '0;
        qif.insBIn   = '0;
        qif.validBIn = 1'b0;
        qif.pcIn     = '0;
    endtask

    // driver: one clock edge with the given controls, then settle 1ns past the edge
    task automatic cycle(input logic f, input logic pu, input logic po,
                         input logic [31:0] a, input logic [31:0] b, input logic vb,
                         input logic [XLEN-1:0] pc);
        qif.flush    = f;
        qif.push     = pu;
        qif.pop      = po;
        qif.insAIn   = a;
        qif.insBIn   = b;
        qif.validBIn = vb;
        qif.pcIn     = pc;
        @(posedge clock);
        model_edge(f, pu, po, pc);
        #1;
        idle_inputs();
    endtask

    task automatic push_pc(input logic [XLEN-1:0] pc);
        cycle(1'b0, 1'b1, 1'b0, 32'h1000_0000 | pc, 32'h2000_0000 | pc, pc[3], pc);
    endtask

    task automatic pop_one();
        cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, 64'(qif.count), 64'(m_count));
        check({tag, ".empty"}, 64'(qif.queueEmpty), 64'(m_count == 0));
        check({tag, ".full"},  64'(qif.queueFull), 64'(m_count == DEPTH));
        if (m_count > 0) check({tag, ".head_pc"}, 64'(qif.pcOut), 64'(exp_q[0]));
        else             check({tag, ".nop_pc"},  64'(qif.pcOut), 64'd0);
    endtask

    task automatic check_empty_outputs(input string tag);
        check({tag, ".empty"},  64'(qif.queueEmpty), 64'd1);
        check({tag, ".full"},   64'(qif.queueFull), 64'd0);
        check({tag, ".count"},  64'(qif.count), 64'd0);
        check({tag, ".insA"},   64'(qif.insA), 64'h13);
        check({tag, ".insB"},   64'(qif.insB), 64'h13);
        check({tag, ".validB"}, 64'(qif.validB), 64'd0);
        check({tag, ".pcOut"},  64'(qif.pcOut), 64'd0);
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        @(posedge clock);
        #1;

        // reset then idle
        check_empty_outputs("reset");

        // single bundle, visible one cycle after the push edge
        cycle(1'b0, 1'b1, 1'b0, 32'h00A00093, 32'h00100113, 1'b1, 32'h100);
        check("one.empty",  64'(qif.queueEmpty), 64'd0);
        check("one.count",  64'(qif.count), 64'd1);
        check("one.insA",   64'(qif.insA), 64'h00A00093);
        check("one.insB",   64'(qif.insB), 64'h00100113);
        check("one.validB", 64'(qif.validB), 64'd1);
        check("one.pcOut",  64'(qif.pcOut), 64'h100);
        pop_one();
        check_empty_outputs("one_pop");

        // pop while empty is ignored
        pop_one();
        check("empty_pop.count", 64'(qif.count), 64'd0);
        check("empty_pop.rdptr", 64'(qif.dbgRdPtr), 64'd1);

        // fill to DEPTH, then a dropped 5th push
        push_pc(32'h0);
        push_pc(32'h8);
        push_pc(32'h10);
        push_pc(32'h18);
        check("fill.full",  64'(qif.queueFull), 64'd1);
        check("fill.count", 64'(qif.count), 64'd4);
        push_pc(32'h20);
        check("drop.count", 64'(qif.count), 64'd4);
        check("drop.head",  64'(qif.pcOut), 64'h0);
        check_model("drop");
        check("drain0.pc", 64'(qif.pcOut), 64'h0);
        pop_one();
        check("drain1.pc", 64'(qif.pcOut), 64'h8);
        pop_one();
        check("drain2.pc", 64'(qif.pcOut), 64'h10);
        pop_one();
        check("drain3.pc", 64'(qif.pcOut), 64'h18);
        check("drain3.insA", 64'(qif.insA), 64'h1000_0018);
        check("drain3.validB", 64'(qif.validB), 64'd1);
        pop_one();
        check("drain.empty", 64'(qif.queueEmpty), 64'd1);

        // empty with push+pop: push wins, no bypass
        cycle(1'b0, 1'b1, 1'b1, 32'h1000_0030, 32'h2000_0030, 1'b0, 32'h30);
        check("epp.count", 64'(qif.count), 64'd1);
        check("epp.pc",    64'(qif.pcOut), 64'h30);
        check("epp.validB", 64'(qif.validB), 64'd0);
        pop_one();

        // full with push+pop: pop proceeds, push rejected
        push_pc(32'h200);
        push_pc(32'h208);
        push_pc(32'h210);
        push_pc(32'h218);
        cycle(1'b0, 1'b1, 1'b1, '0, '0, 1'b0, 32'h220);
        check("fpp.count", 64'(qif.count), 64'd3);
        check("fpp.full",  64'(qif.queueFull), 64'd0);
        check("fpp.pc",    64'(qif.pcOut), 64'h208);
        repeat (3) pop_one();
        check("fpp.empty", 64'(qif.queueEmpty), 64'd1);

        // wrap-around with steady occupancy of two
        push_pc(32'h50);
        push_pc(32'h58);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 32'h1000_0000, 32'h2000_0000, 1'b1, 32'(32'h60 + 8 * i));
            check("wrap.count", 64'(qif.count), 64'd2);
            check_model("wrap");
        end
        check("wrap.final_head", 64'(qif.pcOut), 64'hA0);

        // flush beats simultaneous push and pop
        push_pc(32'hB0);
        check("preflush.count", 64'(qif.count), 64'd3);
        cycle(1'b1, 1'b1, 1'b1, 32'h1000_00C0, 32'h2000_00C0, 1'b1, 32'hC0);
        check_empty_outputs("flush");
        check("flush.rdptr", 64'(qif.dbgRdPtr), 64'd0);
        check("flush.wrptr", 64'(qif.dbgWrPtr), 64'd0);
        @(posedge clock);
        #1;
        check("postflush.count", 64'(qif.count), 64'd0);

        // asynchronous reset mid-cycle with two entries held
        push_pc(32'hD0);
        push_pc(32'hD8);
        check("prerst.count", 64'(qif.count), 64'd2);
        #3 resetn = 1'b0;
        exp_q.delete();
        m_count = 0;
        #1;
        check("arst.empty", 64'(qif.queueEmpty), 64'd1);
        check("arst.count", 64'(qif.count), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        push_pc(32'h40);
        check("rst_push.rdptr", 64'(qif.dbgRdPtr), 64'd0);
        check("rst_push.wrptr", 64'(qif.dbgWrPtr), 64'd1);
        check("rst_push.pc",    64'(qif.pcOut), 64'h40);
        check_model("rst_push");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
